mem_port_responder: RTL and testbench
=====================================

// Module: mem_port_responder
// PURPOSE
//  Memory-side responder for the CPU's split instruction (port 1) and data (port 2) request ports.
//  Arbitrates both request ports onto one physical memory port (pmem_*).
//  Returns read data with a one-cycle resp pulse per port.
//  Sits between cpu_datapath and the backing memory/cache. Data port normally wins; bounded starvation protects fetch.
// PARAMETERS
//  WIDTH         16  address/data width (lc3b_word)
//  STARVE_LIMIT  4   consecutive D grants with port-1 read pending before port 1 is forced (0 = port 1 always wins)
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst           in   1      synchronous, active-high reset
//  mem_addr1     in   WIDTH  port-1 (fetch) address
//  mem_read1     in   1      port-1 read request, held until mem_resp1
//  mem_rdata1    out  WIDTH  port-1 read data, valid while mem_resp1=1
//  mem_resp1     out  1      port-1 completion pulse
//  mem_addr2     in   WIDTH  port-2 (data) address
//  mem_read2     in   1      port-2 read request, held until mem_resp2
//  mem_write2    in   1      port-2 write request, held until mem_resp2
//  mem_wmask2    in   2      port-2 byte write mask
//  mem_wdata2    in   WIDTH  port-2 write data
//  mem_rdata2    out  WIDTH  port-2 read data, valid while mem_resp2=1
//  mem_resp2     out  1      port-2 completion pulse
//  pmem_addr     out  WIDTH  physical memory address
//  pmem_read     out  1      physical read strobe
//  pmem_write    out  1      physical write strobe
//  pmem_wmask    out  2      physical byte mask
//  pmem_wdata    out  WIDTH  physical write data
//  pmem_rdata    in   WIDTH  physical read data, valid with pmem_resp
//  pmem_resp     in   1      physical completion
// BEHAVIOUR
//  - Reset: state IDLE, starve_cnt=0; every output 0, including the rdata registers. All outputs are registered.
//  - FSM has three states: IDLE, SERVE, RESP.
//  - IDLE grant rule (evaluated each cycle):
//    - If (read2|write2) and !(read1 && starve_cnt>=STARVE_LIMIT): grant port 2.
//    - Else if read1: grant port 1.
//    - Otherwise stay in IDLE.
//    - On a grant, capture addr/op/mask/wdata and the granted-port id; go to SERVE.
//  - SERVE:
//    - pmem_* driven from the captured registers; strobes held until pmem_resp.
//    - On pmem_resp: latch pmem_rdata into the granted port's rdata register (reads only), drop strobes, go to RESP.
//  - RESP: the granted port's resp is high for exactly this one cycle. No grant is made in RESP; next state is IDLE.
//  - Latency: request seen in IDLE at cycle 0, so pmem strobe is high at cycle 1. pmem_resp at cycle k gives resp at cycle k+1. Minimum is 2 cycles with a zero-wait memory.
//  - starve_cnt:
//    - +1 (saturating at STARVE_LIMIT) on each port-2 grant while read1=1.
//    - Cleared on each port-1 grant.
//  - read2 and write2 both high: treated as a write; pmem_read stays 0.
//  - Requester drops its request during SERVE: the transaction still completes and resp still pulses.
//  - pmem_resp in IDLE or RESP is ignored.
//  - Port-2 write completion does not alter mem_rdata2.
//  - Each rdata register holds its last read value outside resp.
//  - rst during SERVE or RESP: transaction abandoned; IDLE and all outputs 0 next cycle; no resp issued.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined:
//    - Adds outputs stat_i_grants, stat_d_grants and stat_starve_forced, 16 bits each.
//    - Each counter increments on its event, saturates at 16'hFFFF and is cleared by rst.
//    - stat_starve_forced counts port-1 grants made while port 2 was also requesting.
//  MEM_ARB_STATS_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  - Reset mid-SERVE (after a port-2 grant): next cycle pmem_read=0, resp1=resp2=0, IDLE.
//  - Lone read1 @0x3000, pmem_rdata=0x1234 with 2-cycle memory:
//    pmem_read at cycle 1-2, mem_resp1 at cycle 3 with rdata1=0x1234, one cycle only.
//  - Simultaneous read1 @0x0010 and write2 @0x0020, wdata 0xBEEF, mask 2'b11:
//    port 2 is served first (pmem_write, pmem_wdata=0xBEEF), then port 1.
//  - Continuous read2 plus held read1, STARVE_LIMIT=4: grant order D,D,D,D,I,D...
//    starve_cnt reads 1,2,3,4,0.
//  - read2 and write2 both high: pmem_write=1, pmem_read=0; mem_rdata2 unchanged after resp2.
//  - Spurious pmem_resp in IDLE: no resp pulse, no rdata change.

Source files
------------

// File: rtl/mem_port_responder_if.sv
// rtl/mem_port_responder_if.sv - request ports and physical memory port bundle for mem_port_responder
interface mem_port_responder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] mem_addr1;
  logic             mem_read1;
  logic [WIDTH-1:0] mem_rdata1;
  logic             mem_resp1;
  logic [WIDTH-1:0] mem_addr2;
  logic             mem_read2;
  logic             mem_write2;
  logic [1:0]       mem_wmask2;
  logic [WIDTH-1:0] mem_wdata2;
  logic [WIDTH-1:0] mem_rdata2;
  logic             mem_resp2;
  logic [WIDTH-1:0] pmem_addr;
  logic             pmem_read;
  logic             pmem_write;
  logic [1:0]       pmem_wmask;
  logic [WIDTH-1:0] pmem_wdata;
  logic [WIDTH-1:0] pmem_rdata;
  logic             pmem_resp;

  modport slave (
    input  mem_addr1, mem_read1, mem_addr2, mem_read2, mem_write2, mem_wmask2, mem_wdata2,
    input  pmem_rdata, pmem_resp,
    output mem_rdata1, mem_resp1, mem_rdata2, mem_resp2,
    output pmem_addr, pmem_read, pmem_write, pmem_wmask, pmem_wdata
  );

  modport master (
    output mem_addr1, mem_read1, mem_addr2, mem_read2, mem_write2, mem_wmask2, mem_wdata2,
    output pmem_rdata, pmem_resp,
    input  mem_rdata1, mem_resp1, mem_rdata2, mem_resp2,
    input  pmem_addr, pmem_read, pmem_write, pmem_wmask, pmem_wdata
  );
endinterface

// File: rtl/mem_port_responder.sv
// rtl/mem_port_responder.sv - arbitrates fetch (port 1) and data (port 2) onto one memory port
// Optional grant statistics counters under MEM_ARB_STATS_EN.
module mem_port_responder #(
  parameter int WIDTH        = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_responder_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_i_grants,
  output logic [15:0] stat_d_grants,
  output logic [15:0] stat_starve_forced
`endif
);
  localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    starve_cnt;
  logic             grant1, grant2, d_req, i_starved;
  logic             sel2_q;
  logic [WIDTH-1:0] pmem_addr_q, pmem_wdata_q, rdata1_q, rdata2_q;
  logic [1:0]       pmem_wmask_q;
  logic             pmem_read_q, pmem_write_q, resp1_q, resp2_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Data port wins unless fetch has waited out STARVE_LIMIT data grants.
  always_comb begin
    state_next = state;
    grant1     = 1'b0;
    grant2     = 1'b0;
    d_req      = bus.mem_read2 | bus.mem_write2;
    i_starved  = bus.mem_read1 && (starve_cnt >= LIMIT);
    case (state)
      IDLE: begin
        if (d_req && !i_starved) begin
          grant2     = 1'b1;
          state_next = SERVE;
        end else if (bus.mem_read1) begin
          grant1     = 1'b1;
          state_next = SERVE;
        end
      end
      SERVE:   if (bus.pmem_resp) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      sel2_q       <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      pmem_wmask_q <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      resp1_q      <= 1'b0;
      resp2_q      <= 1'b0;
    end else begin
      resp1_q <= 1'b0;
      resp2_q <= 1'b0;
      if (grant2) begin
        pmem_addr_q  <= bus.mem_addr2;
        pmem_write_q <= bus.mem_write2;
        pmem_read_q  <= bus.mem_read2 & ~bus.mem_write2;
        pmem_wmask_q <= bus.mem_wmask2;
        pmem_wdata_q <= bus.mem_wdata2;
        sel2_q       <= 1'b1;
        if (bus.mem_read1 && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant1) begin
        pmem_addr_q  <= bus.mem_addr1;
        pmem_write_q <= 1'b0;
        pmem_read_q  <= 1'b1;
        pmem_wmask_q <= '0;
        pmem_wdata_q <= '0;
        sel2_q       <= 1'b0;
        starve_cnt   <= '0;
      end
      if (state == SERVE && bus.pmem_resp) begin
        pmem_read_q  <= 1'b0;
        pmem_write_q <= 1'b0;
        if (sel2_q) begin
          resp2_q <= 1'b1;
          if (pmem_read_q) rdata2_q <= bus.pmem_rdata;
        end else begin
          resp1_q  <= 1'b1;
          rdata1_q <= bus.pmem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_grants      <= '0;
      stat_d_grants      <= '0;
      stat_starve_forced <= '0;
    end else begin
      if (grant1 && stat_i_grants != 16'hFFFF) stat_i_grants <= stat_i_grants + 16'd1;
      if (grant2 && stat_d_grants != 16'hFFFF) stat_d_grants <= stat_d_grants + 16'd1;
      if (grant1 && d_req && stat_starve_forced != 16'hFFFF)
        stat_starve_forced <= stat_starve_forced + 16'd1;
    end
  end
`endif

  assign bus.pmem_addr  = pmem_addr_q;
  assign bus.pmem_read  = pmem_read_q;
  assign bus.pmem_write = pmem_write_q;
  assign bus.pmem_wmask = pmem_wmask_q;
  assign bus.pmem_wdata = pmem_wdata_q;
  assign bus.mem_rdata1 = rdata1_q;
  assign bus.mem_resp1  = resp1_q;
  assign bus.mem_rdata2 = rdata2_q;
  assign bus.mem_resp2  = resp2_q;
endmodule

// File: tb/tb_mem_port_responder.sv
// tb/tb_mem_port_responder.sv - self-checking bench for mem_port_responder
module tb_mem_port_responder;
  localparam int WIDTH = 16;
  localparam int LIM   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_responder_if #(.WIDTH(WIDTH)) bus ();
`ifdef MEM_ARB_STATS_EN
  logic [15:0] s_i, s_d, s_f;
`endif

  mem_port_responder #(.WIDTH(WIDTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_i_grants(s_i),
    .stat_d_grants(s_d),
    .stat_starve_forced(s_f)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] mem [0:255];
  int mem_lat = 2;
  int lat_cnt = 0;
  bit force_resp = 1'b0;

  // One clock: sample just after the edge, then the memory model drives pmem_resp/rdata.
  task automatic step();
    @(posedge clk);
    #1;
    if (force_resp) begin
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = 16'hDEAD;
    end else if (bus.pmem_read || bus.pmem_write) begin
      if (lat_cnt >= mem_lat - 1) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = bus.pmem_read ? mem[bus.pmem_addr[7:0]] : 16'($urandom);
        if (bus.pmem_write) begin
          if (bus.pmem_wmask[0]) mem[bus.pmem_addr[7:0]][7:0]  = bus.pmem_wdata[7:0];
          if (bus.pmem_wmask[1]) mem[bus.pmem_addr[7:0]][15:8] = bus.pmem_wdata[15:8];
        end
        lat_cnt = 0;
      end else begin
        lat_cnt++;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 16'($urandom);
      end
    end else begin
      lat_cnt = 0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = 16'($urandom);
    end
  endtask

  task automatic serve_one(input int max, output int port, output logic [15:0] addr,
                           output logic rd, output logic wr, output logic [15:0] wd,
                           output logic [15:0] rdata);
    bit got = 1'b0;
    port = 0; addr = '0; rd = 1'b0; wr = 1'b0; wd = '0; rdata = '0;
    for (int i = 0; i < max; i++) begin
      step();
      if (!got && (bus.pmem_read || bus.pmem_write)) begin
        got = 1'b1; addr = bus.pmem_addr; rd = bus.pmem_read; wr = bus.pmem_write; wd = bus.pmem_wdata;
      end
      if (bus.mem_resp1) begin port = 1; rdata = bus.mem_rdata1; return; end
      if (bus.mem_resp2) begin port = 2; rdata = bus.mem_rdata2; return; end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [86:0] v;
    v = {bus.mem_rdata1, bus.mem_resp1, bus.mem_rdata2, bus.mem_resp2, bus.pmem_addr,
         bus.pmem_read, bus.pmem_write, bus.pmem_wmask, bus.pmem_wdata};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL %s outputs got=%h expected=0", name, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("reset_idle");
  endtask

  task automatic test_lone_read();
    bit exp_rd [1:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit exp_rs [1:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mem[8'h00] = 16'h1234; mem_lat = 2;
    bus.mem_addr1 = 16'h3000; bus.mem_read1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++;
      if (bus.pmem_read !== exp_rd[c] || bus.mem_resp1 !== exp_rs[c]) begin
        failures++;
        $display("FAIL lone_read cycle %0d pmem_read=%b resp1=%b expected %b %b",
                 c, bus.pmem_read, bus.mem_resp1, exp_rd[c], exp_rs[c]);
      end
      if (c == 1) begin
        checks++;
        if (bus.pmem_addr !== 16'h3000) begin
          failures++; $display("FAIL lone_read_addr got=%h expected=3000", bus.pmem_addr);
        end
      end
      if (c == 3 || c == 5) begin
        checks++;
        if (bus.mem_rdata1 !== 16'h1234) begin
          failures++; $display("FAIL lone_read_rdata cycle %0d got=%h expected=1234", c, bus.mem_rdata1);
        end
      end
      if (bus.mem_resp1) bus.mem_read1 = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    int port; logic [15:0] a, wd, rdv; logic rd, wr;
    mem[8'h10] = 16'h5A5A; mem[8'h20] = 16'h0000;
    bus.mem_addr1 = 16'h0010; bus.mem_read1 = 1'b1;
    bus.mem_addr2 = 16'h0020; bus.mem_write2 = 1'b1; bus.mem_read2 = 1'b0;
    bus.mem_wdata2 = 16'hBEEF; bus.mem_wmask2 = 2'b11;
    serve_one(20, port, a, rd, wr, wd, rdv);
    bus.mem_write2 = 1'b0;
    checks++;
    if (port != 2 || a !== 16'h0020 || wr !== 1'b1 || rd !== 1'b0 || wd !== 16'hBEEF) begin
      failures++;
      $display("FAIL simul_first port=%0d addr=%h wr=%b rd=%b wdata=%h expected 2 0020 1 0 beef", port, a, wr, rd, wd);
    end
    serve_one(20, port, a, rd, wr, wd, rdv);
    bus.mem_read1 = 1'b0;
    checks++;
    if (port != 1 || a !== 16'h0010 || rd !== 1'b1 || rdv !== 16'h5A5A) begin
      failures++;
      $display("FAIL simul_second port=%0d addr=%h rd=%b rdata=%h expected 1 0010 1 5a5a", port, a, rd, rdv);
    end
    checks++;
    if (mem[8'h20] !== 16'hBEEF) begin
      failures++; $display("FAIL simul_write_mem got=%h expected=beef", mem[8'h20]);
    end
  endtask

  task automatic test_starvation();
    int port, exp_port, cnt; logic [15:0] a, wd, rdv; logic rd, wr;
    cnt = 0;
    bus.mem_addr1 = 16'h0100; bus.mem_read1 = 1'b1;
    bus.mem_addr2 = 16'h0200; bus.mem_read2 = 1'b1; bus.mem_write2 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (cnt >= LIM) begin exp_port = 1; cnt = 0; end
      else begin exp_port = 2; cnt = cnt + 1; end
      serve_one(20, port, a, rd, wr, wd, rdv);
      checks++;
      if (port != exp_port) begin
        failures++; $display("FAIL starve_order grant %0d port=%0d expected=%0d", t, port, exp_port);
      end
    end
    bus.mem_read1 = 1'b0; bus.mem_read2 = 1'b0;
    step(); step();
  endtask

  task automatic test_rw_both();
    int port; logic [15:0] a, wd, rdv; logic rd, wr;
    mem[8'h30] = 16'h7777; mem[8'h31] = 16'hFFFF;
    bus.mem_addr2 = 16'h0030; bus.mem_read2 = 1'b1; bus.mem_write2 = 1'b0;
    serve_one(20, port, a, rd, wr, wd, rdv);
    bus.mem_read2 = 1'b0;
    checks++;
    if (port != 2 || rdv !== 16'h7777) begin
      failures++; $display("FAIL rw_setup port=%0d rdata2=%h expected 2 7777", port, rdv);
    end
    bus.mem_addr2 = 16'h0031; bus.mem_read2 = 1'b1; bus.mem_write2 = 1'b1;
    bus.mem_wdata2 = 16'h0102; bus.mem_wmask2 = 2'b01;
    serve_one(20, port, a, rd, wr, wd, rdv);
    bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
    checks++;
    if (port != 2 || wr !== 1'b1 || rd !== 1'b0 || bus.mem_rdata2 !== 16'h7777) begin
      failures++;
      $display("FAIL rw_both port=%0d wr=%b rd=%b rdata2=%h expected 2 1 0 7777", port, wr, rd, bus.mem_rdata2);
    end
    checks++;
    if (mem[8'h31] !== 16'hFF02) begin
      failures++; $display("FAIL rw_mask mem=%h expected=ff02", mem[8'h31]);
    end
  endtask

  task automatic test_spurious();
    logic [15:0] r1, r2;
    step();
    r1 = bus.mem_rdata1; r2 = bus.mem_rdata2;
    force_resp = 1'b1;
    step();
    force_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.mem_resp1 !== 1'b0 || bus.mem_resp2 !== 1'b0 || bus.mem_rdata1 !== r1 ||
          bus.mem_rdata2 !== r2 || bus.pmem_read !== 1'b0) begin
        failures++;
        $display("FAIL spurious cycle %0d resp1=%b resp2=%b rdata1=%h rdata2=%h expected 0 0 %h %h",
                 c, bus.mem_resp1, bus.mem_resp2, bus.mem_rdata1, bus.mem_rdata2, r1, r2);
      end
    end
  endtask

  task automatic test_reset_mid_serve();
    mem_lat = 8;
    bus.mem_addr2 = 16'h0040; bus.mem_read2 = 1'b1; bus.mem_write2 = 1'b0;
    step(); step();
    checks++;
    if (bus.pmem_read !== 1'b1) begin
      failures++; $display("FAIL mid_serve_setup pmem_read=%b expected=1", bus.pmem_read);
    end
    rst = 1'b1;
    step();
    check_all_zero("mid_serve_reset");
    rst = 1'b0; bus.mem_read2 = 1'b0; mem_lat = 2;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.mem_resp1 !== 1'b0 || bus.mem_resp2 !== 1'b0 || bus.pmem_read !== 1'b0) begin
        failures++;
        $display("FAIL mid_serve_after cycle %0d resp1=%b resp2=%b pmem_read=%b expected 0 0 0",
                 c, bus.mem_resp1, bus.mem_resp2, bus.pmem_read);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ref_mem [0:255];
    bit p1, p2, prev_strobe, strobe, r2, w2, want2;
    int cnt, exp_port, exp_now, done;
    logic [15:0] exp_addr;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    cnt = 0; exp_port = 0; prev_strobe = 1'b0; done = 0; r2 = 1'b0; w2 = 1'b0;
    bus.mem_read1 = 1'b0; bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p1 = bus.mem_read1; p2 = bus.mem_read2 | bus.mem_write2;
      step();
      strobe = bus.pmem_read | bus.pmem_write;
      if (strobe && !prev_strobe) begin
        want2 = p2 && !(p1 && cnt >= LIM);
        exp_now = want2 ? 2 : (p1 ? 1 : 0);
        if (exp_now == 2 && p1) cnt = (cnt < LIM) ? cnt + 1 : cnt;
        if (exp_now == 1) cnt = 0;
        exp_addr = (exp_now == 2) ? bus.mem_addr2 : bus.mem_addr1;
        checks++;
        if (exp_now == 0 || bus.pmem_addr !== exp_addr ||
            bus.pmem_write !== (exp_now == 2 && w2) ||
            bus.pmem_read !== (exp_now == 1 || (r2 && !w2)) ||
            (exp_now == 2 && w2 && (bus.pmem_wdata !== bus.mem_wdata2 || bus.pmem_wmask !== bus.mem_wmask2))) begin
          failures++;
          $display("FAIL rand_grant cycle %0d expected port %0d addr=%h got addr=%h rd=%b wr=%b",
                   cyc, exp_now, exp_addr, bus.pmem_addr, bus.pmem_read, bus.pmem_write);
        end
        exp_port = exp_now;
      end
      prev_strobe = strobe;
      if (!strobe) mem_lat = $urandom_range(1, 3);
      if (bus.mem_resp1 || bus.mem_resp2) begin
        checks++;
        if ((bus.mem_resp1 ? 1 : 2) != exp_port || (bus.mem_resp1 && bus.mem_resp2)) begin
          failures++;
          $display("FAIL rand_resp_port cycle %0d resp1=%b resp2=%b expected port %0d",
                   cyc, bus.mem_resp1, bus.mem_resp2, exp_port);
        end
        if (bus.mem_resp1) begin
          checks++;
          if (bus.mem_rdata1 !== ref_mem[bus.mem_addr1[7:0]]) begin
            failures++;
            $display("FAIL rand_rdata1 got=%h expected=%h", bus.mem_rdata1, ref_mem[bus.mem_addr1[7:0]]);
          end
          bus.mem_read1 = 1'b0;
        end
        if (bus.mem_resp2) begin
          if (w2) begin
            if (bus.mem_wmask2[0]) ref_mem[bus.mem_addr2[7:0]][7:0]  = bus.mem_wdata2[7:0];
            if (bus.mem_wmask2[1]) ref_mem[bus.mem_addr2[7:0]][15:8] = bus.mem_wdata2[15:8];
          end else begin
            checks++;
            if (bus.mem_rdata2 !== ref_mem[bus.mem_addr2[7:0]]) begin
              failures++;
              $display("FAIL rand_rdata2 got=%h expected=%h", bus.mem_rdata2, ref_mem[bus.mem_addr2[7:0]]);
            end
          end
          bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
        end
        exp_port = 0;
        done++;
      end
      if (!bus.mem_read1 && $urandom_range(0, 3) == 0) begin
        bus.mem_addr1 = 16'($urandom_range(0, 15));
        bus.mem_read1 = 1'b1;
      end
      if (!(bus.mem_read2 || bus.mem_write2) && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        r2 = (op != 1); w2 = (op != 0);
        bus.mem_addr2  = 16'($urandom_range(0, 15));
        bus.mem_wdata2 = 16'($urandom);
        bus.mem_wmask2 = 2'($urandom_range(0, 3));
        bus.mem_read2  = r2; bus.mem_write2 = w2;
      end
    end
    checks++;
    if (done < 100) begin
      failures++; $display("FAIL rand_progress completed=%0d expected at least 100", done);
    end
    bus.mem_read1 = 1'b0; bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
    for (int c = 0; c < 12; c++) step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst = 1'b1;
    bus.mem_addr1 = '0; bus.mem_read1 = 1'b0;
    bus.mem_addr2 = '0; bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
    bus.mem_wmask2 = '0; bus.mem_wdata2 = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    test_reset();
    test_lone_read();
    test_simultaneous();
    test_starvation();
    test_rw_both();
    test_spurious();
    test_reset_mid_serve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
